pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the five-stage pipeline (IF, ID, EX, MEM, WB). It detects read-after-write hazards on the register file and stalls the front end, since the datapath has no forwarding. It flushes wrong-path instructions when a branch resolves taken in MEM, and it drains and halts the pipeline on request. It drives the PC and IF/ID write enables and the per-buffer flush/bubble controls, and keeps saturating stall and flush counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, branch-flush and drain/halt sequencing for a five-stage pipeline without forwarding.
// Enables and flush controls are Mealy outputs; state and debug counters are registered.
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             RegWrite_EX,
    input  logic             RegWrite_MEM,
    input  logic             RegWrite_WB,
    input  logic [4:0]       WriteReg_EX,
    input  logic [4:0]       WriteReg_MEM,
    input  logic [4:0]       WriteReg_WB,
    input  logic             BranchTaken_MEM,
    input  logic             HaltReq,
    input  logic             Resume,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             EXMEMFlush,
    output logic             Halted,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             halted_q, halted_d;
    logic             hit_rs, hit_rt, hz;

    function automatic logic src_hit(input logic [4:0] src, input logic we, input logic [4:0] wr);
        return we && (wr == src) && (src != 5'd0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // With a write-before-read register bank the WB stage never conflicts.
    always_comb begin
        hit_rs = src_hit(Rs_ID, RegWrite_EX, WriteReg_EX) |
                 src_hit(Rs_ID, RegWrite_MEM, WriteReg_MEM) |
                 (!WB_BYPASS && src_hit(Rs_ID, RegWrite_WB, WriteReg_WB));
        hit_rt = src_hit(Rt_ID, RegWrite_EX, WriteReg_EX) |
                 src_hit(Rt_ID, RegWrite_MEM, WriteReg_MEM) |
                 (!WB_BYPASS && src_hit(Rt_ID, RegWrite_WB, WriteReg_WB));
        hz     = hit_rs | (UsesRt_ID & hit_rt);
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        EXMEMFlush = 1'b0;
        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (BranchTaken_MEM) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (hz) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (state_q != ST_RUN) begin
            // PC holds the first unissued instruction; nops fill IF/ID.
            PCWrite   = 1'b0;
            IFIDFlush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (BranchTaken_MEM)
            flush_d = sat_inc(flush_q);
        else if (hz)
            stall_d = sat_inc(stall_q);
        case (state_q)
            ST_RUN: begin
                if (HaltReq) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (BranchTaken_MEM)
                    dcnt_d = 2'd0;
                else if (!hz) begin
                    if (dcnt_q == 2'd3)
                        state_d = ST_HALTED;
                    else
                        dcnt_d = dcnt_q + 2'd1;
                end
            end
            ST_HALTED: begin
                if (Resume)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_RUN;
            dcnt_q   <= 2'd0;
            stall_q  <= '0;
            flush_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    assign State    = state_q;
    assign Halted   = halted_q;
    assign StallCnt = stall_q;
    assign FlushCnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no bypass / 16-bit counters, bypass / 2-bit counters)
// share stimulus; a reference model pushes expected values that a negedge monitor pops.
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [4:0] Rs_ID, Rt_ID, WriteReg_EX, WriteReg_MEM, WriteReg_WB;
    logic       UsesRt_ID, RegWrite_EX, RegWrite_MEM, RegWrite_WB;
    logic       BranchTaken_MEM, HaltReq, Resume;

    logic        pcw0, ifw0, iff0, idb0, exf0, hl0;
    logic [1:0]  st0;
    logic [15:0] sc0, fc0;
    logic        pcw1, ifw1, iff1, idb1, exf1, hl1;
    logic [1:0]  st1;
    logic [1:0]  sc1, fc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.CNT_W(16), .WB_BYPASS(1'b0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .WriteReg_EX(WriteReg_EX), .WriteReg_MEM(WriteReg_MEM), .WriteReg_WB(WriteReg_WB),
        .BranchTaken_MEM(BranchTaken_MEM), .HaltReq(HaltReq), .Resume(Resume),
        .PCWrite(pcw0), .IFIDWrite(ifw0), .IFIDFlush(iff0), .IDEXBubble(idb0),
        .EXMEMFlush(exf0), .Halted(hl0), .State(st0), .StallCnt(sc0), .FlushCnt(fc0)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .WB_BYPASS(1'b1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .WriteReg_EX(WriteReg_EX), .WriteReg_MEM(WriteReg_MEM), .WriteReg_WB(WriteReg_WB),
        .BranchTaken_MEM(BranchTaken_MEM), .HaltReq(HaltReq), .Resume(Resume),
        .PCWrite(pcw1), .IFIDWrite(ifw1), .IFIDFlush(iff1), .IDEXBubble(idb1),
        .EXMEMFlush(exf1), .Halted(hl1), .State(st1), .StallCnt(sc1), .FlushCnt(fc1)
    );

    typedef struct {
        logic [1:0][4:0]  ctl;
        logic [1:0][1:0]  st;
        logic [1:0]       hl;
        logic [1:0][15:0] sc;
        logic [1:0][15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [1:0] m_st[2];
    int         m_dc[2], m_sc[2], m_fc[2];
    logic       m_hl[2];
    logic [1:0] n_st[2];
    int         n_dc[2], n_sc[2], n_fc[2];
    logic       n_hl[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic bit hits(input int v, input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        return (RegWrite_EX && WriteReg_EX == s) || (RegWrite_MEM && WriteReg_MEM == s) ||
               (v == 0 && RegWrite_WB && WriteReg_WB == s);
    endfunction

    // Evaluate the reference for the inputs now applied, push expectations, advance one clock.
    task automatic tick();
        exp_t e;
        bit   hz;
        int   mx;
        for (int v = 0; v < 2; v++) begin
            mx = (v == 0) ? 65535 : 3;
            if (Rst) begin
                m_st[v] = 2'b00; m_dc[v] = 0; m_sc[v] = 0; m_fc[v] = 0; m_hl[v] = 1'b0;
            end
            hz = hits(v, Rs_ID) || (UsesRt_ID && hits(v, Rt_ID));
            if (Rst)                  e.ctl[v] = 5'b00111;
            else if (BranchTaken_MEM) e.ctl[v] = 5'b11111;
            else if (hz)              e.ctl[v] = 5'b00010;
            else if (m_st[v] == 2'b00) e.ctl[v] = 5'b11000;
            else                      e.ctl[v] = 5'b01100;
            e.st[v] = m_st[v];
            e.hl[v] = m_hl[v];
            e.sc[v] = 16'(m_sc[v]);
            e.fc[v] = 16'(m_fc[v]);
            n_st[v] = m_st[v]; n_dc[v] = m_dc[v]; n_sc[v] = m_sc[v]; n_fc[v] = m_fc[v];
            if (!Rst) begin
                if (BranchTaken_MEM) n_fc[v] = (m_fc[v] < mx) ? m_fc[v] + 1 : mx;
                else if (hz)         n_sc[v] = (m_sc[v] < mx) ? m_sc[v] + 1 : mx;
                if (m_st[v] == 2'b00 && HaltReq) begin
                    n_st[v] = 2'b01; n_dc[v] = 0;
                end else if (m_st[v] == 2'b01) begin
                    if (BranchTaken_MEM) n_dc[v] = 0;
                    else if (!hz) begin
                        if (m_dc[v] == 3) n_st[v] = 2'b10;
                        else n_dc[v] = m_dc[v] + 1;
                    end
                end else if (m_st[v] == 2'b10 && Resume) begin
                    n_st[v] = 2'b00;
                end
            end
            n_hl[v] = (n_st[v] == 2'b10);
        end
        exp_q.push_back(e);
        @(posedge Clk);
        for (int v = 0; v < 2; v++) begin
            m_st[v] = n_st[v]; m_dc[v] = n_dc[v]; m_sc[v] = n_sc[v]; m_fc[v] = n_fc[v]; m_hl[v] = n_hl[v];
        end
        #1;
    endtask

    task automatic clr();
        Rst = 1'b0; Rs_ID = 5'd0; Rt_ID = 5'd0; UsesRt_ID = 1'b0;
        RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
        WriteReg_EX = 5'd0; WriteReg_MEM = 5'd0; WriteReg_WB = 5'd0;
        BranchTaken_MEM = 1'b0; HaltReq = 1'b0; Resume = 1'b0;
    endtask

    task automatic do_reset();
        clr(); Rst = 1'b1; tick(); clr();
    endtask

    task automatic raw_src(input logic [4:0] s, input int stage);
        clr(); Rs_ID = s; Rt_ID = 5'd3; UsesRt_ID = 1'b1;
        case (stage)
            0: begin RegWrite_EX = 1'b1;  WriteReg_EX = s;  end
            1: begin RegWrite_MEM = 1'b1; WriteReg_MEM = s; end
            2: begin RegWrite_WB = 1'b1;  WriteReg_WB = s;  end
            default: ;
        endcase
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ctl0", {27'd0, pcw0, ifw0, iff0, idb0, exf0}, {27'd0, mon_e.ctl[0]});
            chk("ctl1", {27'd0, pcw1, ifw1, iff1, idb1, exf1}, {27'd0, mon_e.ctl[1]});
            chk("state0", {30'd0, st0}, {30'd0, mon_e.st[0]});
            chk("state1", {30'd0, st1}, {30'd0, mon_e.st[1]});
            chk("halted0", {31'd0, hl0}, {31'd0, mon_e.hl[0]});
            chk("halted1", {31'd0, hl1}, {31'd0, mon_e.hl[1]});
            chk("stall0", {16'd0, sc0}, {16'd0, mon_e.sc[0]});
            chk("stall1", {30'd0, sc1}, {16'd0, mon_e.sc[1]});
            chk("flush0", {16'd0, fc0}, {16'd0, mon_e.fc[0]});
            chk("flush1", {30'd0, fc1}, {16'd0, mon_e.fc[1]});
        end
    end

    initial begin
        clr(); Rst = 1'b1;
        @(posedge Clk); #1;
        do_reset();
        chk("rst_state", {30'd0, st0}, 32'd0);
        clr(); tick();

        // RAW: producer passes EX, MEM, WB in front of a stalled consumer.
        for (int s = 0; s < 4; s++) begin raw_src(5'd1, s); tick(); end
        chk("raw_stall0", {16'd0, sc0}, 32'd3);
        chk("raw_stall1", {30'd0, sc1}, 32'd2);

        // Register zero never conflicts; Rt only matters when it is read.
        do_reset();
        for (int s = 0; s < 3; s++) begin raw_src(5'd0, s); Rt_ID = 5'd0; tick(); end
        chk("r0_stall", {16'd0, sc0}, 32'd0);
        clr(); Rt_ID = 5'd7; RegWrite_MEM = 1'b1; WriteReg_MEM = 5'd7; tick();
        UsesRt_ID = 1'b1; tick();
        chk("rt_stall", {16'd0, sc0}, 32'd1);

        // Taken branch coinciding with a hazard: flush wins, no stall counted.
        do_reset();
        raw_src(5'd2, 0); BranchTaken_MEM = 1'b1; #1;
        chk("br_pcw", {31'd0, pcw0}, 32'd1);
        chk("br_exf", {31'd0, exf0}, 32'd1);
        tick();
        clr(); tick();
        chk("br_flushcnt", {16'd0, fc0}, 32'd1);
        chk("br_stallcnt", {16'd0, sc0}, 32'd0);

        // Halt: one-cycle request, four DRAIN cycles, then HALTED.
        do_reset();
        HaltReq = 1'b1; tick(); clr();
        for (int i = 0; i < 4; i++) begin chk("drain_state", {30'd0, st0}, 32'd1); tick(); end
        chk("halt_state", {30'd0, st0}, 32'd2);
        chk("halt_flag", {31'd0, hl0}, 32'd1);
        chk("halt_pcw", {31'd0, pcw0}, 32'd0);
        HaltReq = 1'b1; tick(); clr();
        Resume = 1'b1; tick(); clr();
        chk("resume_state", {30'd0, st0}, 32'd0);
        chk("resume_pcw", {31'd0, pcw0}, 32'd1);
        Resume = 1'b1; tick(); clr(); tick();

        // DRAIN with a stall (counter holds) and a branch (counter restarts).
        do_reset();
        HaltReq = 1'b1; tick(); clr();
        tick();
        raw_src(5'd4, 0); tick(); clr();
        tick();
        BranchTaken_MEM = 1'b1; tick(); clr();
        for (int i = 0; i < 3; i++) tick();
        chk("drain_br_state", {30'd0, st0}, 32'd1);
        tick();
        chk("drain_br_halt", {30'd0, st0}, 32'd2);
        BranchTaken_MEM = 1'b1; tick(); clr(); tick();

        // Asynchronous reset in the middle of DRAIN.
        do_reset();
        HaltReq = 1'b1; tick();
        raw_src(5'd5, 1); tick(); clr(); tick();
        Rst = 1'b1; #1;
        chk("arst_state", {30'd0, st0}, 32'd0);
        chk("arst_stall", {16'd0, sc0}, 32'd0);
        chk("arst_pcw", {31'd0, pcw0}, 32'd0);
        chk("arst_iff", {31'd0, iff0}, 32'd1);
        tick(); clr(); tick();

        // Saturation on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin raw_src(5'd9, 0); tick(); end
        clr();
        chk("sat_stall1", {30'd0, sc1}, 32'd3);
        chk("sat_stall0", {16'd0, sc0}, 32'd5);
        for (int i = 0; i < 4; i++) begin BranchTaken_MEM = 1'b1; tick(); end
        clr(); tick();
        chk("sat_flush1", {30'd0, fc1}, 32'd3);

        // Randomised traffic with small register numbers to provoke hits.
        for (int i = 0; i < 400; i++) begin
            Rst = ($urandom_range(0, 63) == 0);
            Rs_ID = 5'($urandom_range(0, 3)); Rt_ID = 5'($urandom_range(0, 3));
            UsesRt_ID = 1'($urandom_range(0, 1));
            RegWrite_EX = 1'($urandom_range(0, 1)); WriteReg_EX = 5'($urandom_range(0, 5));
            RegWrite_MEM = 1'($urandom_range(0, 1)); WriteReg_MEM = 5'($urandom_range(0, 5));
            RegWrite_WB = 1'($urandom_range(0, 1)); WriteReg_WB = 5'($urandom_range(0, 5));
            BranchTaken_MEM = ($urandom_range(0, 7) == 0);
            HaltReq = ($urandom_range(0, 5) == 0);
            Resume = ($urandom_range(0, 3) == 0);
            tick();
        end
        clr(); tick();

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
